int_arbiter: RTL and testbench
==============================

# int_arbiter

Interrupt source arbiter in front of the core status/sequencing unit. Synchronizes external NMI and IRQ pins, latches NMI edges, and masks and prioritizes N_IRQ level-sensitive lines. Merges soft-reset and BRK requests, then presents exactly one request (rst, nmi, irq or brk) to the status unit, holding it until acknowledged. Also exposes a small config port for per-line IRQ masking and a cause index for the vector/dispatch logic.

## Interface
- N_IRQ, 8: number of level-sensitive IRQ lines (2..16); line 0 is highest priority.
- SYNC_STAGES, 2: flip-flop stages on each asynchronous pin (>=2).
- CW, $clog2(N_IRQ): width of irq_cause.

- clk  in  1  single clock; all logic on rising edge.
- a_rst  in  1  asynchronous, active-high reset.
- nmi_pin  in  1  async, NMI requested on falling edge.
- irq_pin  in  N_IRQ  async, active-high level requests.
- rst_req  in  1  sync one-cycle soft-reset request.
- brk_req  in  1  sync one-cycle BRK request from decode.
- int_taken  in  1  one-cycle pulse when the core replaces IR with the vector jump; acknowledges rst and brk.
- nmi_ack  in  1  one-cycle NMI acknowledge from status unit.
- irq_ack  in  1  one-cycle IRQ acknowledge from status unit.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  1  0: mask register, 1: reserved (write ignored).
- cfg_wdata  in  N_IRQ  write data; bit=1 masks that line.
- cfg_mask  out  N_IRQ  current mask register.
- rst  out  1  reset request to status unit.
- nmi  out  1  NMI request.
- irq  out  1  IRQ request.
- brk  out  1  BRK request.
- irq_cause  out  CW  index of serviced IRQ line.
- busy  out  1  high in any state except S_IDLE.

## Operation
- Reset values: rst=1, nmi=0, irq=0, brk=0, irq_cause=0, cfg_mask=all ones, busy=1, state S_RST, nmi_pend=0, brk_pend=0, synchronizers all ones for nmi and zeros for irq.
- Pending sources:
  - nmi_pend: set on a 1->0 transition of the synchronized nmi_pin. Cleared by nmi_ack. Set wins if set and clear coincide.
  - brk_pend: set by brk_req, cleared by int_taken in S_BRK.
  - irq_vec = synchronized irq_pin & ~cfg_mask.
  - rst_req: a new request, not latched; takes effect from any state.
- FSM states (encoding in package): S_RST, S_IDLE, S_NMI, S_IRQ, S_BRK. Exactly one of rst/nmi/irq/brk is high, and only in its matching state.
  - S_RST: rst=1. On int_taken -> S_IDLE.
  - S_IDLE: priority rst_req > nmi_pend > |irq_vec > brk_pend. Go to S_RST / S_NMI / S_IRQ / S_BRK.
    - On the transition to S_IRQ, latch irq_cause = lowest set index of irq_vec.
    - No request: stay.
  - S_NMI: nmi=1; on nmi_ack -> S_IDLE.
  - S_IRQ: irq=1, irq_cause frozen. On irq_ack -> S_IDLE.
    - Committed: stays asserted even if the line drops or is masked before the ack.
  - S_BRK: brk=1; on int_taken -> S_IDLE.
  - Any state: rst_req -> S_RST next cycle. The outstanding request deasserts, and nmi_pend and brk_pend are kept.
- No preemption: an NMI arriving in S_IRQ waits and wins at the next S_IDLE.
- Acks arriving in a non-matching state are ignored.
- Config: cfg_we with cfg_addr=0 loads cfg_mask next cycle. Masking affects only new S_IDLE arbitration.

## Timing
- Outputs are registered; decisions use registered state.
- irq_pin rise -> irq high: SYNC_STAGES+1 cycles (idle, unmasked).
- nmi_pin fall -> nmi high: SYNC_STAGES+2 cycles (edge detect + arbitration).
- brk_req -> brk high: 2 cycles.
- rst_req -> rst high: 1 cycle.
- Ack in cycle t -> request low at t+1, S_IDLE at t+1, next grant at t+2 at the earliest. Minimum gap of one idle cycle between requests.
- a_rst mid-operation clears everything to reset values immediately; a pending NMI is lost.

## Structure
- Shared package int_pkg: state enum (S_RST, S_IDLE, S_NMI, S_IRQ, S_BRK), the priority order constant, and the vector-select encoding matching the status unit (BRK 00, NMI 01, RST 10, IRQ 11).
- Sub-module int_sync: parameterized width/stages/reset-value synchronizer, instantiated for nmi_pin (reset 1) and irq_pin (reset 0).
- Priority encoder is a function in int_pkg.

## Test plan
- Reset release: a_rst 1->0 -> rst=1, busy=1, cfg_mask=8'hFF. Pulse int_taken -> rst=0, busy=0 next cycle.
- Single IRQ, mask=8'hF7, raise irq_pin[3] -> irq=1 after 3 cycles, irq_cause=3. Drop irq_pin[3] before the ack -> irq stays 1. irq_ack -> irq=0.
- Priority: mask=0, hold irq_pin=8'b0110_0000 and pulse brk_req together with an nmi_pin fall. Required grant order:
  - nmi first;
  - then irq with irq_cause=5;
  - then irq again with cause 5 while the level is held;
  - then brk only after irq_pin clears.
- NMI re-arm: a second nmi_pin fall synchronized in the same cycle as nmi_ack -> nmi re-asserts after one S_IDLE cycle.
- Soft reset mid-service: in S_IRQ pulse rst_req -> next cycle irq=0, rst=1. int_taken -> S_IDLE. A previously latched nmi_pend is then granted.
- Masked line: mask=8'h01, irq_pin[0]=1 -> irq stays 0 for 20 cycles. Write mask=0 -> irq=1 two cycles after the write, irq_cause=0.

Source files
------------

// File: rtl/int_pkg.sv
// Shared types and helpers for the interrupt arbiter and its status-unit consumers.
package int_pkg;

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_IDLE = 3'd1,
    S_NMI  = 3'd2,
    S_IRQ  = 3'd3,
    S_BRK  = 3'd4
  } state_t;

  // Vector-select encoding shared with the status unit.
  typedef enum logic [1:0] {
    VEC_BRK = 2'b00,
    VEC_NMI = 2'b01,
    VEC_RST = 2'b10,
    VEC_IRQ = 2'b11
  } vsel_t;

  // Arbitration order, highest priority in the top slot.
  localparam logic [7:0] PRIO_ORDER = {VEC_RST, VEC_NMI, VEC_IRQ, VEC_BRK};

  // Index of the lowest set bit (line 0 is the highest-priority IRQ).
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--)
      if (v[i]) r = 4'(i);
    return r;
  endfunction

endpackage

// File: rtl/int_sync.sv
// Multi-stage synchronizer for asynchronous pins with a configurable reset value.
module int_sync #(
  parameter int              W       = 1,
  parameter int              STAGES  = 2,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         a_rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] ff;

  // Shift the pin through STAGES flops; the oldest stage is the safe output.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) ff <= {STAGES{RST_VAL}};
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/int_arbiter.sv
// Interrupt source arbiter: syncs NMI/IRQ pins, latches NMI edges and BRK, and
// presents one request at a time to the status unit until it is acknowledged.
module int_arbiter
  import int_pkg::*;
#(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CW          = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             nmi_pin,
  input  logic [N_IRQ-1:0] irq_pin,
  input  logic             rst_req,
  input  logic             brk_req,
  input  logic             int_taken,
  input  logic             nmi_ack,
  input  logic             irq_ack,
  input  logic             cfg_we,
  input  logic             cfg_addr,
  input  logic [N_IRQ-1:0] cfg_wdata,
  output logic [N_IRQ-1:0] cfg_mask,
  output logic             rst,
  output logic             nmi,
  output logic             irq,
  output logic             brk,
  output logic [CW-1:0]    irq_cause,
  output logic             busy
);

  state_t           state, state_d;
  logic             nmi_s, nmi_prev, nmi_pend, brk_pend;
  logic [N_IRQ-1:0] irq_s, irq_vec;
  logic [3:0]       req;
  logic             found;
  vsel_t            win, sel;

  // NMI idles high, so its synchronizer resets to 1 to avoid a false edge.
  int_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_nmi_sync (
    .clk(clk), .a_rst(a_rst), .d(nmi_pin), .q(nmi_s)
  );

  int_sync #(.W(N_IRQ), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_irq_sync (
    .clk(clk), .a_rst(a_rst), .d(irq_pin), .q(irq_s)
  );

  assign irq_vec = irq_s & ~cfg_mask;

  // NMI falling-edge latch; a new edge wins over a coincident acknowledge.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      nmi_prev <= 1'b1;
      nmi_pend <= 1'b0;
    end else begin
      nmi_prev <= nmi_s;
      if (nmi_prev && !nmi_s)              nmi_pend <= 1'b1;
      else if (state == S_NMI && nmi_ack)  nmi_pend <= 1'b0;
    end
  end

  // BRK latch, retired only when the core takes the BRK vector.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst)                             brk_pend <= 1'b0;
    else if (brk_req)                      brk_pend <= 1'b1;
    else if (state == S_BRK && int_taken)  brk_pend <= 1'b0;
  end

  // Mask register; address 1 is reserved and writes to it are dropped.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst)                    cfg_mask <= '1;
    else if (cfg_we && !cfg_addr) cfg_mask <= cfg_wdata;
  end

  // Pick the highest-priority live source by walking the priority table.
  always_comb begin
    req          = '0;
    req[VEC_RST] = rst_req;
    req[VEC_NMI] = nmi_pend;
    req[VEC_IRQ] = |irq_vec;
    req[VEC_BRK] = brk_pend;
    found        = 1'b0;
    win          = VEC_BRK;
    sel          = VEC_BRK;
    for (int i = 3; i >= 0; i--) begin
      sel = vsel_t'(PRIO_ORDER[2*i +: 2]);
      if (!found && req[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
  end

  // Next-state: grants happen only from idle; soft reset overrides everything.
  always_comb begin
    state_d = state;
    case (state)
      S_RST:  if (int_taken) state_d = S_IDLE;
      S_IDLE: if (found) begin
        case (win)
          VEC_RST: state_d = S_RST;
          VEC_NMI: state_d = S_NMI;
          VEC_IRQ: state_d = S_IRQ;
          default: state_d = S_BRK;
        endcase
      end
      S_NMI:  if (nmi_ack)   state_d = S_IDLE;
      S_IRQ:  if (irq_ack)   state_d = S_IDLE;
      S_BRK:  if (int_taken) state_d = S_IDLE;
      default:               state_d = S_RST;
    endcase
    if (rst_req) state_d = S_RST;
  end

  // State register.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) state <= S_RST;
    else       state <= state_d;
  end

  // Cause is captured on the grant and stays frozen while the IRQ is serviced.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst)
      irq_cause <= '0;
    else if (state == S_IDLE && state_d == S_IRQ)
      irq_cause <= CW'(lowest_set(16'(irq_vec)));
  end

  assign rst  = (state == S_RST);
  assign nmi  = (state == S_NMI);
  assign irq  = (state == S_IRQ);
  assign brk  = (state == S_BRK);
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_int_arbiter.sv
// Scoreboard bench for int_arbiter: expected grants are queued as stimulus is
// applied and compared as the arbiter raises each new request.
module tb_int_arbiter;

  localparam int N_IRQ = 8;
  localparam int CW    = 3;
  localparam logic [3:0] K_RST = 4'b1000, K_NMI = 4'b0100, K_IRQ = 4'b0010, K_BRK = 4'b0001;

  logic             clk = 1'b0;
  logic             a_rst, nmi_pin, rst_req, brk_req, int_taken, nmi_ack, irq_ack;
  logic             cfg_we, cfg_addr;
  logic [N_IRQ-1:0] irq_pin, cfg_wdata, cfg_mask;
  logic             rst, nmi, irq, brk, busy;
  logic [CW-1:0]    irq_cause;

  int errs  = 0;
  int total = 0;
  logic [7:0] exp_q[$];

  int_arbiter #(.N_IRQ(N_IRQ), .SYNC_STAGES(2)) dut (
    .clk(clk), .a_rst(a_rst), .nmi_pin(nmi_pin), .irq_pin(irq_pin),
    .rst_req(rst_req), .brk_req(brk_req), .int_taken(int_taken),
    .nmi_ack(nmi_ack), .irq_ack(irq_ack), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_mask(cfg_mask), .rst(rst), .nmi(nmi), .irq(irq),
    .brk(brk), .irq_cause(irq_cause), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Grant monitor: every newly raised request is popped against the scoreboard.
  logic [3:0] prev_g = K_RST;
  always @(negedge clk) begin
    logic [3:0] g;
    logic [7:0] e;
    g = {rst, nmi, irq, brk};
    if (a_rst) prev_g = g;
    else begin
      chk("onehot", 32'($onehot0(g)), 32'd1);
      if (g != prev_g && g != 4'd0) begin
        if (exp_q.size() == 0) chk("unexpected_grant", 32'(g), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("grant", 32'({g, (irq ? 4'(irq_cause) : 4'd0)}), 32'(e));
        end
      end
      prev_g = g;
    end
  end

  initial begin
    a_rst = 1; nmi_pin = 1; irq_pin = '0; rst_req = 0; brk_req = 0;
    int_taken = 0; nmi_ack = 0; irq_ack = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = '0;

    // Reset state and release
    step(3);
    chk("rst_rst", rst, 1); chk("rst_busy", busy, 1); chk("rst_mask", cfg_mask, 8'hFF);
    chk("rst_outs", {nmi, irq, brk}, 3'b000); chk("rst_cause", irq_cause, 0);
    a_rst = 0;
    step(1); chk("rel_rst", rst, 1);
    int_taken = 1; step(1); int_taken = 0;
    chk("rel_rst_lo", rst, 0); chk("rel_busy_lo", busy, 0);

    // Single IRQ on line 3, plus an ignored write to the reserved address
    cfg_we = 1; cfg_addr = 0; cfg_wdata = 8'hF7; step(1);
    cfg_addr = 1; cfg_wdata = 8'h00; step(1); cfg_we = 0; cfg_addr = 0;
    chk("mask_f7", cfg_mask, 8'hF7);
    irq_pin[3] = 1; exp_q.push_back({K_IRQ, 4'd3});
    step(2); chk("irq3_early", irq, 0);
    step(1); chk("irq3_hi", irq, 1); chk("irq3_cause", irq_cause, 3);
    irq_pin = '0; step(4);
    chk("irq3_held", irq, 1); chk("irq3_cause_frozen", irq_cause, 3);
    irq_ack = 1; step(1); irq_ack = 0;
    chk("irq3_ack", irq, 0); chk("irq3_idle", busy, 0);

    // Priority: all sources collected while parked in S_RST, then released
    cfg_we = 1; cfg_wdata = 8'h00; step(1); cfg_we = 0;
    rst_req = 1; exp_q.push_back({K_RST, 4'd0}); step(1); rst_req = 0;
    chk("srst_rst", rst, 1);
    irq_pin = 8'b0110_0000; nmi_pin = 0; brk_req = 1; step(1); brk_req = 0;
    step(5);
    exp_q.push_back({K_NMI, 4'd0}); exp_q.push_back({K_IRQ, 4'd5});
    exp_q.push_back({K_IRQ, 4'd5}); exp_q.push_back({K_BRK, 4'd0});
    int_taken = 1; step(1); int_taken = 0; chk("prio_idle", busy, 0);
    step(1); chk("prio_nmi", nmi, 1); nmi_pin = 1;
    nmi_ack = 1; step(1); nmi_ack = 0; chk("prio_gap", busy, 0);
    step(1); chk("prio_irq1", irq, 1); chk("prio_cause1", irq_cause, 5);
    irq_ack = 1; step(1); irq_ack = 0;
    step(1); chk("prio_irq2", irq, 1); chk("prio_cause2", irq_cause, 5);
    irq_pin = '0; step(3);
    irq_ack = 1; step(1); irq_ack = 0;
    step(1); chk("prio_brk", brk, 1);
    int_taken = 1; step(1); int_taken = 0; chk("prio_done", busy, 0);

    // NMI re-arm: second edge lands on the same cycle as the acknowledge
    nmi_pin = 0; exp_q.push_back({K_NMI, 4'd0}); exp_q.push_back({K_NMI, 4'd0});
    step(3); chk("nmi_early", nmi, 0);
    step(1); chk("nmi_hi", nmi, 1);
    nmi_pin = 1; step(3);
    nmi_pin = 0; step(2);
    nmi_ack = 1; step(1); nmi_ack = 0;
    chk("rearm_gap", nmi, 0); chk("rearm_idle", busy, 0);
    step(1); chk("rearm_nmi", nmi, 1);
    nmi_ack = 1; step(1); nmi_ack = 0; chk("rearm_ack", nmi, 0);
    nmi_pin = 1; step(3);

    // Soft reset during IRQ service keeps a latched NMI
    irq_pin = 8'h04; exp_q.push_back({K_IRQ, 4'd2});
    step(3); chk("sr_irq", irq, 1); chk("sr_cause", irq_cause, 2);
    nmi_pin = 0; step(4);
    chk("sr_no_preempt", {nmi, irq}, 2'b01);
    nmi_pin = 1;
    rst_req = 1; exp_q.push_back({K_RST, 4'd0}); step(1); rst_req = 0;
    irq_pin = '0;
    chk("sr_irq_lo", irq, 0); chk("sr_rst_hi", rst, 1);
    step(2);
    exp_q.push_back({K_NMI, 4'd0});
    int_taken = 1; step(1); int_taken = 0; chk("sr_idle", {rst, busy}, 2'b00);
    step(1); chk("sr_nmi", nmi, 1);
    nmi_ack = 1; step(1); nmi_ack = 0;

    // Masked line stays silent until unmasked
    cfg_we = 1; cfg_wdata = 8'h01; step(1); cfg_we = 0;
    irq_pin = 8'h01;
    for (int i = 0; i < 20; i++) begin
      step(1); chk("masked_quiet", irq, 0);
    end
    cfg_we = 1; cfg_wdata = 8'h00; exp_q.push_back({K_IRQ, 4'd0});
    step(1); cfg_we = 0;
    chk("unmask_early", irq, 0); chk("unmask_reg", cfg_mask, 8'h00);
    step(1); chk("unmask_irq", irq, 1); chk("unmask_cause", irq_cause, 0);
    irq_pin = '0; step(2);
    irq_ack = 1; step(1); irq_ack = 0; chk("unmask_ack", irq, 0);

    // BRK latency, then async reset drops a pending NMI
    brk_req = 1; exp_q.push_back({K_BRK, 4'd0}); step(1); brk_req = 0;
    chk("brk_early", brk, 0);
    step(1); chk("brk_hi", brk, 1);
    nmi_pin = 0; step(3); nmi_pin = 1; step(1);
    #2 a_rst = 1;
    #1 chk("arst_rst", rst, 1); chk("arst_brk", brk, 0);
    chk("arst_busy", busy, 1); chk("arst_mask", cfg_mask, 8'hFF);
    step(2); a_rst = 0; step(2);
    int_taken = 1; step(1); int_taken = 0; chk("arst_idle", busy, 0);
    step(4); chk("arst_nmi_lost", {nmi, busy}, 2'b00);

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule
